// File: rtl/bus_switch_arb_if.sv
// bus_switch_arb_if: requester handshake plus registered switch-side bus for bus_switch_arb.
// req_lock exists only when BUS_ARB_LOCK_EN is defined.
interface bus_switch_arb_if #(
   parameter int NREQ = 4,
   parameter int AW   = 8,
   parameter int DW   = 16
);
   localparam int SW = $clog2(NREQ);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
`ifdef BUS_ARB_LOCK_EN
   logic [NREQ-1:0]    req_lock;
`endif
   logic [NREQ-1:0]    req_ready;
   logic               bus_valid;
   logic [AW-1:0]      bus_addr;
   logic [DW-1:0]      bus_data;
   logic [SW-1:0]      bus_src;
`ifdef BUS_ARB_LOCK_EN
   modport master (output req_valid, req_addr, req_data, req_lock,
                   input req_ready, bus_valid, bus_addr, bus_data, bus_src);
   modport slave  (input req_valid, req_addr, req_data, req_lock,
                   output req_ready, bus_valid, bus_addr, bus_data, bus_src);
`else
   modport master (output req_valid, req_addr, req_data,
                   input req_ready, bus_valid, bus_addr, bus_data, bus_src);
   modport slave  (input req_valid, req_addr, req_data,
                   output req_ready, bus_valid, bus_addr, bus_data, bus_src);
`endif
endinterface

// File: rtl/bus_switch_arb.sv
// bus_switch_arb: round-robin arbiter registering one requester beat per cycle onto the switch input.
// Defining BUS_ARB_LOCK_EN adds req_lock and a LOCK state for bursts of up to MAX_BURST beats.
module bus_switch_arb #(
   parameter int NREQ      = 4,
   parameter int AW        = 8,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            reset,
   bus_switch_arb_if.slave b
);
   localparam int SW = $clog2(NREQ);
   typedef enum logic {ARB, LOCK} state_t;
   state_t          state_q, state_d;
   logic [SW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win, sel, k;
   logic [3:0]      cnt_q, cnt_d;
   logic            found, xfer;
   logic [NREQ-1:0] lock;
   logic            bus_valid_q, bus_valid_d;
   logic [AW-1:0]   bus_addr_q, bus_addr_d;
   logic [DW-1:0]   bus_data_q, bus_data_d;
   logic [SW-1:0]   bus_src_q, bus_src_d;
`ifdef BUS_ARB_LOCK_EN
   assign lock = b.req_lock;
`else
   assign lock = '0;
`endif
   always_comb begin
      found = 1'b0;
      win   = '0;
      k     = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = SW'((int'(ptr_q) + i) % NREQ);
         if (!found && b.req_valid[k]) begin
            found = 1'b1;
            win   = k;
         end
      end
   end
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      sel        = state_q == LOCK ? owner_q : win;
      xfer       = !reset && (state_q == LOCK ? b.req_valid[owner_q] : found);
      bus_valid_d = xfer;
      bus_addr_d = bus_addr_q;
      bus_data_d = bus_data_q;
      bus_src_d  = xfer ? sel : bus_src_q;
      for (int i = 0; i < NREQ; i++) begin
         if (xfer && SW'(i) == sel) begin
            bus_addr_d = b.req_addr[i*AW +: AW];
            bus_data_d = b.req_data[i*DW +: DW];
         end
      end
      b.req_ready = xfer ? NREQ'(1) << sel : '0;
      if (state_q == ARB) begin
         if (found) begin
            ptr_d = win == SW'(NREQ - 1) ? '0 : win + 1'b1;
            // a single-beat limit never needs the LOCK state
            if (lock[win] && MAX_BURST > 1) begin
               state_d = LOCK;
               owner_d = win;
               cnt_d   = 4'd1;
            end
         end
      end else begin
         cnt_d = cnt_q + 4'd1;
         if (!xfer || !lock[owner_q] || cnt_d >= 4'(MAX_BURST)) state_d = ARB;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         bus_valid_q <= 1'b0;
         bus_addr_q  <= '0;
         bus_data_q  <= '0;
         bus_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         bus_valid_q <= bus_valid_d;
         bus_addr_q  <= bus_addr_d;
         bus_data_q  <= bus_data_d;
         bus_src_q   <= bus_src_d;
      end
   end
   assign b.bus_valid = bus_valid_q;
   assign b.bus_addr  = bus_addr_q;
   assign b.bus_data  = bus_data_q;
   assign b.bus_src   = bus_src_q;
endmodule

// File: doc/bus_switch_arb.md
# bus_switch_arb

Round-robin arbiter that shares the single input port of the two-way bus switch among `NREQ` requesters. Each requester presents address/data with a valid/ready handshake. Each cycle one winner is granted, and its beat is registered onto the switch input (`valid`/`addr`/`data`). The switch has no back-pressure, so the arbiter sustains one beat per cycle.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, 8: address width; matches the switch `addr_in`.
- `DW`, 16: data width; matches the switch `data_in`.
- `MAX_BURST`, 4: maximum consecutive locked beats per grant, 1..15. Used only with `BUS_ARB_LOCK_EN`.
- `SW` (localparam), `$clog2(NREQ)`: width of the source index.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i has a beat.
- `req_addr`  in  NREQ*AW  packed; requester i occupies bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  packed; requester i occupies bits [i*DW +: DW].
- `req_lock`  in  NREQ  bit i: requester i asks to keep the grant. Present only with `BUS_ARB_LOCK_EN`.
- `req_ready`  out  NREQ  one-hot-or-zero grant, combinational from current inputs and state.
- `bus_valid`  out  1  drives the switch `valid`.
- `bus_addr`  out  AW  drives the switch `addr_in`.
- `bus_data`  out  DW  drives the switch `data_in`.
- `bus_src`  out  SW  index of the requester whose beat is on the bus.

## Operation
- **Transfer rule:** a beat from requester i transfers when `req_valid[i] && req_ready[i]`.
  - `req_ready[i]` may depend on `req_valid[i]`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Arbitration (state ARB):**
  - Search starts at `ptr` and scans upward modulo `NREQ`.
  - The first asserted `req_valid` wins; its `req_ready` goes high and the beat transfers.
  - `ptr` is then set to (winner+1) mod NREQ.
  - If no `req_valid` is asserted, `ptr` is unchanged.
- **Registering:** on a transfer, on the next edge `bus_valid`=1 and `bus_addr`/`bus_data`/`bus_src` take the winner's values.
  - With no transfer, `bus_valid`=0 and `bus_addr`/`bus_data`/`bus_src` hold their last values.
- **Switch side:** no ready; every registered beat is accepted by the switch.
- **Reset:**
  - Outputs: `bus_valid`=0, `bus_addr`=0, `bus_data`=0, `bus_src`=0, `req_ready`=0.
  - Internal: `ptr`=0, state=ARB, beat counter=0.
  - Reset mid-burst drops the lock and discards any beat not yet registered.
- **Simultaneous requests:** all NREQ asserted continuously gives the grant order ptr, ptr+1, …, each requester once per NREQ cycles.

## Timing
- Latency from transfer edge to `bus_valid`: 1 cycle. Throughput: 1 beat per cycle.
- `req_ready` is 0 during the cycle in which `reset` is high.
- A requester dropping `req_valid` before being granted loses nothing; no state is kept for it.
- `ptr` wraps from NREQ-1 to 0.

## Configuration
- **Macro:** `BUS_ARB_LOCK_EN`.
- **Defined:** adds the `req_lock` input and a LOCK state.
  - **Entry:** in ARB, a winner with `req_lock[w]`=1 moves the block to LOCK with owner=w and count=1.
  - **In LOCK:** only the owner can be granted.
  - **Each owner transfer:** count increments.
  - **Return to ARB** after the edge on which any of these holds:
    - the owner's `req_lock` is 0 at its transfer;
    - count reaches `MAX_BURST`;
    - the owner's `req_valid` is 0 (no transfer that cycle; the cycle is idle on the bus).
  - **On LOCK exit:** `ptr` = owner+1.
  - **Lock with MAX_BURST=1:** behaves as plain round robin.
- **Undefined:** no `req_lock` port; the state machine is ARB only, and the result is functionally identical to the defined build with all `req_lock`=0.

## Test plan
- **Reset:**
  - Stimulus: hold `reset` 2 cycles with all `req_valid`=1.
  - Required: `req_ready`=0, and `bus_valid`/`bus_addr`/`bus_data`/`bus_src` all 0.
  - Required: the first grant after release goes to requester 0.
- **Single requester:**
  - Stimulus: requester 2 sends addr 8'h10 / data 16'h1234 for one cycle.
  - Required: `req_ready[2]`=1 that cycle.
  - Required, next cycle: `bus_valid`=1, `bus_addr`=8'h10, `bus_data`=16'h1234, `bus_src`=2; `bus_valid`=0 the cycle after.
- **Full contention:**
  - Stimulus: all 4 requesters valid for 8 cycles, each with data 16'hA000+i.
  - Required: `bus_src` sequence 0,1,2,3,0,1,2,3 with back-to-back `bus_valid`.
- **Wrap and skip:**
  - Stimulus: after requester 3 is granted, only requesters 1 and 3 are valid.
  - Required: grants alternate 1,3,1,3; requester 0 is skipped with no idle cycles.
- **Lock (with `BUS_ARB_LOCK_EN`, MAX_BURST=4):**
  - Stimulus: requester 1 holds `req_lock` with 6 beats while requester 0 is also valid.
  - Required: `bus_src`=1 for 4 beats, then 0, then 1.
- **Lock release:**
  - Stimulus: locked owner drops `req_valid`.
  - Required: one idle bus cycle, then another requester is granted on the next cycle.
